// File: rtl/sccb_write_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sccb_write_master : 3-phase SCCB write (device ID, register, data) master.
// Rev 1.0
// ---------------------------------------------------------------------------
module sccb_write_master #(
  parameter int unsigned clk_freq    = 25000000,
  parameter int unsigned sccb_freq   = 100000,
  parameter logic [7:0]  camera_addr = 8'h42
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SCCB_start,
  input  logic [7:0] SCCB_addr,
  input  logic [7:0] SCCB_reg,
  output logic       SCCB_ready,
  output logic       SIO_C,
  output logic       SIO_D,
  output logic       SIO_D_oe
);

  localparam int unsigned QUARTER  = clk_freq / (4 * sccb_freq);
  localparam int unsigned CNT_W    = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(QUARTER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [4:0] LAST_BIT = 5'd26;

  generate
    if (QUARTER < 1) begin : g_bad_quarter
      $error("sccb_write_master: clk_freq/(4*sccb_freq) must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START_A = 3'd1,
    START_B = 3'd2,
    BITS    = 3'd3,
    STOP_A  = 3'd4,
    STOP_B  = 3'd5,
    STOP_C  = 3'd6
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       bit_idx;
  logic [4:0]       next_idx;
  logic [1:0]       quarter;
  logic [7:0]       addr_q;
  logic [7:0]       data_q;
  logic [26:0]      frame;
  logic             next_dc;

  // Don't-care slots are zero in the frame so SIO_D reads 0 while released.
  assign frame    = {camera_addr, 1'b0, addr_q, 1'b0, data_q, 1'b0};
  assign next_idx = bit_idx + 5'd1;
  assign next_dc  = (next_idx == 5'd8) || (next_idx == 5'd17) || (next_idx == 5'd26);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      quarter    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      SCCB_ready <= 1'b1;
      SIO_C      <= 1'b1;
      SIO_D      <= 1'b1;
      SIO_D_oe   <= 1'b1;
    end else if (state == IDLE) begin
      if (SCCB_start) begin
        addr_q     <= SCCB_addr;
        data_q     <= SCCB_reg;
        cnt        <= CNT_LOAD;
        bit_idx    <= '0;
        quarter    <= '0;
        state      <= START_A;
        SCCB_ready <= 1'b0;
        SIO_C      <= 1'b1;
        SIO_D      <= 1'b0;
        SIO_D_oe   <= 1'b1;
      end
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_ONE;
    end else begin
      cnt <= CNT_LOAD;
      case (state)
        START_A: begin
          state <= START_B;
          SIO_C <= 1'b0;
          SIO_D <= 1'b0;
        end
        START_B: begin
          state    <= BITS;
          bit_idx  <= '0;
          quarter  <= '0;
          SIO_C    <= 1'b0;
          SIO_D    <= frame[LAST_BIT];
          SIO_D_oe <= 1'b1;
        end
        BITS: begin
          if (quarter != 2'd3) begin
            // Clock goes high entering quarter 2 and stays high through 3.
            quarter <= quarter + 2'd1;
            SIO_C   <= (quarter != 2'd0);
          end else if (bit_idx == LAST_BIT) begin
            state    <= STOP_A;
            SIO_C    <= 1'b0;
            SIO_D    <= 1'b0;
            SIO_D_oe <= 1'b1;
          end else begin
            bit_idx  <= next_idx;
            quarter  <= '0;
            SIO_C    <= 1'b0;
            SIO_D    <= frame[LAST_BIT - next_idx];
            SIO_D_oe <= !next_dc;
          end
        end
        STOP_A: begin
          state <= STOP_B;
          SIO_C <= 1'b1;
          SIO_D <= 1'b0;
        end
        STOP_B: begin
          state <= STOP_C;
          SIO_C <= 1'b1;
          SIO_D <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          bit_idx    <= '0;
          quarter    <= '0;
          SCCB_ready <= 1'b1;
          SIO_C      <= 1'b1;
          SIO_D      <= 1'b1;
          SIO_D_oe   <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
